// File: rtl/pa2_pkg.sv
// Shared definitions for the pa2 sequence-match counter: state encoding and default width.
package pa2_pkg;

   localparam int unsigned W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      HIT   = 2'b10
   } state_t;

endpackage

// File: rtl/pa2_match_fsm.sv
// Sequence-match counter: counts seq==num while a sequence is presented, then
// replays the match count as a burst of hit cycles before returning to idle.
module pa2_match_fsm
   import pa2_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         valid,
   input  logic [W-1:0] num,
   input  logic [W-1:0] seq,
   output logic [1:0]   state,
   output logic [1:0]   n_state,
   output logic [W-1:0] cnt,
   output logic [W-1:0] n_cnt,
   output logic         hit
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   state_t       st_q;
   state_t       st_n;
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_n;
   logic         hit_q;

   // State, counter and the registered Moore hit flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q  <= IDLE;
         cnt_q <= '0;
         hit_q <= 1'b0;
      end else begin
         st_q  <= st_n;
         cnt_q <= cnt_n;
         hit_q <= (st_n == HIT);
      end
   end

   // Next-state and next-count; the encoding 2'b11 falls into default and recovers to IDLE
   always_comb begin
      st_n  = IDLE;
      cnt_n = '0;
      unique case (st_q)
         IDLE: begin
            if (valid) st_n = COUNT;
         end
         COUNT: begin
            // the element on the exit edge is still compared, independent of valid
            if ((seq == num) && (cnt_q != CNT_MAX)) cnt_n = cnt_q + W'(1);
            else                                    cnt_n = cnt_q;
            if (valid)              st_n = COUNT;
            else if (cnt_n != '0)   st_n = HIT;
            else                    st_n = IDLE;
         end
         HIT: begin
            cnt_n = cnt_q - W'(1);
            st_n  = (cnt_q == W'(1)) ? IDLE : HIT;
         end
         default: begin
            st_n  = IDLE;
            cnt_n = '0;
         end
      endcase
   end

   assign state   = st_q;
   assign n_state = st_n;
   assign cnt     = cnt_q;
   assign n_cnt   = cnt_n;
   assign hit     = hit_q;

endmodule

// File: tb/tb_pa2_match_fsm.sv
// Bench for pa2_match_fsm: directed table, random sequences against a match-count model,
// and hand-written reset / valid-during-burst sequences.
module tb_pa2_match_fsm;

   localparam int unsigned W = 4;
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_COUNT = 2'b01;
   localparam logic [1:0] S_HIT   = 2'b10;

   logic         clock;
   logic         reset;
   logic         valid;
   logic [W-1:0] num;
   logic [W-1:0] seq;
   logic [1:0]   state;
   logic [1:0]   n_state;
   logic [W-1:0] cnt;
   logic [W-1:0] n_cnt;
   logic         hit;

   int tests  = 0;
   int failed = 0;

   pa2_match_fsm #(.W(W)) dut (
      .clock   (clock),
      .reset   (reset),
      .valid   (valid),
      .num     (num),
      .seq     (seq),
      .state   (state),
      .n_state (n_state),
      .cnt     (cnt),
      .n_cnt   (n_cnt),
      .hit     (hit)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0]      num;
      logic [9:0][W-1:0] s;
      int                len;
      int                exp_m;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // one clock, then settle away from the edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference: hit burst length is the number of matching elements, clipped to the counter range
   function automatic int model_hits(input logic [W-1:0] n, input logic [9:0][W-1:0] s,
                                     input int len);
      int m = 0;
      for (int i = 0; i < len; i++) if (s[i] == n) m++;
      if (m > (1 << W) - 1) m = (1 << W) - 1;
      return m;
   endfunction

   // Presents a sequence from IDLE and checks the whole count/hit burst cycle by cycle
   task automatic run_seq(input string name, input logic [W-1:0] n,
                          input logic [9:0][W-1:0] s, input int len, input int exp_m);
      num   = n;
      seq   = ~n;
      valid = 1'b1;
      step();
      chk({name, "_enter"}, int'(state), int'(S_COUNT));
      for (int i = 0; i < len; i++) begin
         seq   = s[i];
         valid = (i < len - 1);
         step();
      end
      valid = 1'b0;
      chk({name, "_exit_state"}, int'(state), (exp_m > 0) ? int'(S_HIT) : int'(S_IDLE));
      for (int k = exp_m; k >= 1; k--) begin
         chk({name, "_hit"}, int'(hit), 1);
         chk({name, "_cnt"}, int'(cnt), k);
         step();
      end
      chk({name, "_done_state"}, int'(state), int'(S_IDLE));
      chk({name, "_done_hit"}, int'(hit), 0);
      chk({name, "_done_cnt"}, int'(cnt), 0);
   endtask

   initial begin
      logic [9:0][W-1:0] s;
      logic [W-1:0]      n;
      int                len;

      vecs[0] = '{num: 4'd5,  s: {10{4'd10}}, len: 10, exp_m: 0};
      vecs[1] = '{num: 4'd5,  s: {10{4'd5}},  len: 10, exp_m: 10};
      vecs[2] = '{num: 4'd5,  s: {10{4'd10}}, len: 1,  exp_m: 0};
      vecs[3] = '{num: 4'd5,  s: {10{4'd5}},  len: 1,  exp_m: 1};
      vecs[4] = '{num: 4'd3,  s: {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd3, 4'd3, 4'd0, 4'd3},
                  len: 6, exp_m: 4};
      vecs[5] = '{num: 4'd15, s: {10{4'd15}}, len: 7,  exp_m: 7};

      reset = 1'b0;
      valid = 1'b0;
      num   = '0;
      seq   = '0;
      #12;
      chk("reset_state", int'(state), int'(S_IDLE));
      chk("reset_cnt", int'(cnt), 0);
      chk("reset_hit", int'(hit), 0);
      reset = 1'b1;
      repeat (2) step();
      chk("idle_hold", int'(state), int'(S_IDLE));

      for (int i = 0; i < 6; i++) begin
         run_seq($sformatf("vec%0d", i), vecs[i].num, vecs[i].s, vecs[i].len, vecs[i].exp_m);
         repeat (3) step();
      end

      for (int r = 0; r < 5; r++) begin
         n   = W'($urandom_range(0, 15));
         len = int'($urandom_range(1, 10));
         for (int i = 0; i < 10; i++)
            s[i] = ($urandom_range(0, 1) == 1) ? n : W'($urandom_range(0, 15));
         run_seq($sformatf("rand%0d", r), n, s, len, model_hits(n, s, len));
         repeat (11) step();
      end

      // Reset in the middle of COUNT
      num = 4'd5; valid = 1'b1; seq = 4'd5;
      step();
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      chk("rst_count_state", int'(state), int'(S_IDLE));
      chk("rst_count_cnt", int'(cnt), 0);
      chk("rst_count_hit", int'(hit), 0);
      valid = 1'b0;
      #3 reset = 1'b1;
      step();
      run_seq("after_rst_count", 4'd5, {10{4'd5}}, 4, 4);

      // Reset in the middle of a hit burst
      num = 4'd5; valid = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         seq   = 4'd5;
         valid = (i < 9);
         step();
      end
      repeat (3) step();
      chk("pre_rst_hit", int'(hit), 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_hit_state", int'(state), int'(S_IDLE));
      chk("rst_hit_cnt", int'(cnt), 0);
      chk("rst_hit_hit", int'(hit), 0);
      #3 reset = 1'b1;
      step();
      s = {10{4'd2}};
      s[1] = 4'd7;
      run_seq("after_rst_hit", 4'd2, s, 3, 2);

      // valid raised during a 3-cycle burst is ignored until IDLE
      num = 4'd9; valid = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         seq   = 4'd9;
         valid = (i < 2);
         step();
      end
      valid = 1'b1;
      seq   = 4'd0;
      for (int k = 3; k >= 1; k--) begin
         chk("burst_valid_hit", int'(hit), 1);
         chk("burst_valid_cnt", int'(cnt), k);
         step();
      end
      chk("burst_valid_idle", int'(state), int'(S_IDLE));
      chk("burst_valid_nohit", int'(hit), 0);
      step();
      chk("burst_valid_new_count", int'(state), int'(S_COUNT));
      valid = 1'b0;
      step();
      chk("burst_valid_new_exit", int'(state), int'(S_IDLE));
      chk("burst_valid_new_hit", int'(hit), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pa2_match_fsm.md
Name: pa2_match_fsm

Overview:
- Sequence-match counter FSM. While a sequence is presented, it compares each `seq` value against a reference `num` and counts the matches.
- When the sequence ends, it asserts `hit` for exactly as many consecutive cycles as there were matches, then returns to idle.
- Standalone control block. Current and next state and count are exported for debug and visibility.

Parameters:
- W, 4, width of `num`, `seq`, `cnt` and `n_cnt`.

Ports:
- clock    in   1   system clock; all state updates on the rising edge.
- reset    in   1   asynchronous, active-low reset; name kept as `reset`.
- valid    in   1   sequence-active qualifier.
- num      in   W   reference value.
- seq      in   W   current sequence element.
- state    out  2   registered state.
- n_state  out  2   combinational next state.
- cnt      out  W   registered match/hit counter.
- n_cnt    out  W   combinational next counter.
- hit      out  1   Moore output: 1 iff state==HIT.

Behaviour:
- One clock; reset is asynchronous and active-low. While reset is low: state=IDLE, cnt=0, hence hit=0. The reset takes effect immediately, including mid-sequence or mid-hit burst; any partial count is discarded.
- State encoding: IDLE=2'b00, COUNT=2'b01, HIT=2'b10. 2'b11 is illegal and recovers to IDLE with n_cnt=0.
- IDLE:
  - n_cnt=0.
  - If valid=1, n_state=COUNT; else stay IDLE.
  - No comparison is made in IDLE: the edge that first sees valid=1 only enters COUNT.
- COUNT:
  - Every cycle, n_cnt = cnt + (seq==num), saturating at 2^W-1.
  - The comparison is made regardless of valid.
  - If valid=1, stay COUNT.
  - If valid=0, the element present on that edge is still counted. Then n_state = HIT if the updated n_cnt is nonzero, else IDLE (no hit pulse for zero matches).
  - Consequence: with valid raised one cycle before the first element and dropped on the cycle the last element is presented, exactly L elements are compared for a length-L sequence.
- HIT:
  - hit=1 and n_cnt=cnt-1.
  - If cnt==1, n_state=IDLE; else stay HIT.
  - valid, seq and num are ignored.
  - hit is therefore high for exactly N consecutive cycles, where N is the match count, starting the cycle after COUNT exits.
- Latency: hit first rises one clock after the edge on which COUNT sees valid=0.
- A new valid pulse during HIT is ignored. It is accepted only once in IDLE.
- All outputs are glitch-free relative to the clock. hit depends only on registered state.

Decomposition:
- Shared package pa2_pkg: state enum or localparams (IDLE, COUNT, HIT) and the default W.
- No sub-module. Structure: one sequential process for state/cnt and one combinational process for n_state/n_cnt. Optionally a tiny saturating counter helper; single-file RTL is preferred.

Test Plan:
- Reset, then a 10-element sequence with seq=~num (num=5, seq=10) -> cnt=0 at COUNT exit, state COUNT->IDLE directly, hit never asserted.
- 10-element sequence with seq=num=5 -> cnt=10 at COUNT exit; hit high exactly 10 consecutive cycles starting the cycle after exit, cnt counting 10..1; then IDLE and hit=0.
- Length-1 sequence, no match -> IDLE->COUNT->IDLE, hit stays 0. Length-1 sequence, match -> hit high exactly 1 cycle.
- Five random sequences of length 1..10 with random seq -> hit high exactly (number of seq==num among the presented elements) cycles, never extra; 11 idle cycles between runs.
- Assert reset (low) mid-COUNT and mid-HIT -> state=IDLE, cnt=0, hit=0 immediately, without waiting for a clock edge; a subsequent sequence behaves normally.
- Raise valid while in HIT with cnt=3 -> burst still lasts 3 cycles; the new sequence starts only from IDLE.
